// File: rtl/fft_sdf_stage.sv
// fft_sdf_stage: radix-2 single-path delay-feedback butterfly stage.
// Pairs samples H = 2^(STG-1) apart inside each 2^STG sub-block. Sums leave
// immediately; differences are parked in the delay line and drained during the
// next sub-block's load phase, or on idle cycles after the last block.
// Build option: define FFT_SDF_SCALE_EN to round every sum/difference back to
// DATA_W bits with (x+1)>>>1; otherwise results wrap modulo 2^DATA_W.
module fft_sdf_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int STG    = 7
) (
  input  logic                iclk,
  input  logic                rst,
  input  logic                ien,
  input  logic [ADDR_W-1:0]   iaddr,
  input  logic [2*DATA_W-1:0] idata,
  output logic                oen,
  output logic [ADDR_W-1:0]   oaddr,
  output logic [2*DATA_W-1:0] odata
);

  localparam int H     = 1 << (STG - 1);
  localparam int CNT_W = (STG > 1) ? STG - 1 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(H - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t               state;
  logic [CNT_W-1:0]     drain_cnt;
  logic                 started;
  logic [2*DATA_W-1:0]  dline [H];

  logic                 phase, blk_end, calc, load;
  logic                 drain_idle, drain_emit, shift;
  logic [2*DATA_W-1:0]  tail, sum_w, diff_w, push_w;

  // Only the sub-block position bits steer this stage; the rest of the
  // frame address travels along implicitly through the output counter.
  logic unused_iaddr;
  assign unused_iaddr = ^iaddr;

  // One butterfly leg for one component, with the selected result handling.
  function automatic logic [DATA_W-1:0] bfly(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic              sub);
`ifdef FFT_SDF_SCALE_EN
    logic signed [DATA_W:0] w;
    w = sub ? ({a[DATA_W-1], a} - {b[DATA_W-1], b})
            : ({a[DATA_W-1], a} + {b[DATA_W-1], b});
    w = w + (DATA_W+1)'(1);
    return w[DATA_W:1];
`else
    return sub ? (a - b) : (a + b);
`endif
  endfunction

  assign tail       = dline[H-1];
  assign phase      = iaddr[STG-1];
  assign blk_end    = ien && (iaddr[STG-1:0] == '1);
  assign calc       = ien && phase;
  assign load       = ien && !phase;
  // Idle cycles only drain until the next block has started loading.
  assign drain_idle = (state == DRAIN) && !ien && !started;
  assign drain_emit = (state == DRAIN) && (load || drain_idle);
  assign shift      = ien || drain_idle;

  assign sum_w  = {bfly(tail[2*DATA_W-1:DATA_W], idata[2*DATA_W-1:DATA_W], 1'b0),
                   bfly(tail[DATA_W-1:0],        idata[DATA_W-1:0],        1'b0)};
  assign diff_w = {bfly(tail[2*DATA_W-1:DATA_W], idata[2*DATA_W-1:DATA_W], 1'b1),
                   bfly(tail[DATA_W-1:0],        idata[DATA_W-1:0],        1'b1)};

  // Word entering the head of the delay line: difference, raw sample or zero.
  always_comb begin
    push_w = '0;
    if (calc)      push_w = diff_w;
    else if (load) push_w = idata;
  end

  // Delay line: data storage only, so no reset; contents are overwritten
  // before they can ever reach the output.
  always_ff @(posedge iclk) begin
    if (shift) begin
      dline[0] <= push_w;
      for (int i = 1; i < H; i++) dline[i] <= dline[i-1];
    end
  end

  // Drain controller: a block end (re)starts a drain of H stored differences.
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      started   <= 1'b0;
    end else if (blk_end) begin
      state     <= DRAIN;
      drain_cnt <= '0;
      started   <= 1'b0;
    end else if (state == DRAIN) begin
      if (load) started <= 1'b1;
      if (drain_emit) begin
        if (drain_cnt == CNT_LAST) begin
          state     <= IDLE;
          drain_cnt <= '0;
        end else begin
          drain_cnt <= drain_cnt + 1'b1;
        end
      end
    end
  end

  // Registered outputs: calc sum beats drain, idle emits zero with oen low.
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      oen   <= 1'b0;
      odata <= '0;
      oaddr <= '1;
    end else begin
      oen <= calc || drain_emit;
      if (calc)            odata <= sum_w;
      else if (drain_emit) odata <= tail;
      else                 odata <= '0;
      if (calc || drain_emit) oaddr <= oaddr + 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_sdf_stage.sv
// Testbench for fft_sdf_stage (STG=2, ADDR_W=3, DATA_W=16).
// Directed steps follow the documented scenarios; a randomized section
// compares the output stream with a block-level reference model. Expected
// values follow FFT_SDF_SCALE_EN when that macro is defined for the build.
module tb_fft_sdf_stage;

  localparam int DW  = 16;
  localparam int AW  = 3;
  localparam int ST  = 2;
  localparam int H   = 1 << (ST - 1);
  localparam int BLK = 1 << ST;

  logic          iclk = 1'b0;
  logic          rst  = 1'b1;
  logic          ien  = 1'b0;
  logic [AW-1:0] iaddr = '0;
  logic [2*DW-1:0] idata = '0;
  logic          oen;
  logic [AW-1:0] oaddr;
  logic [2*DW-1:0] odata;

  fft_sdf_stage #(.DATA_W(DW), .ADDR_W(AW), .STG(ST)) dut (
    .iclk  (iclk),
    .rst   (rst),
    .ien   (ien),
    .iaddr (iaddr),
    .idata (idata),
    .oen   (oen),
    .oaddr (oaddr),
    .odata (odata)
  );

  always #5 iclk = ~iclk;

  int n_pass = 0;
  int n_fail = 0;
  logic [AW-1:0]   ia = '0;
  logic [AW-1:0]   exp_addr = '0;
  logic [2*DW-1:0] exp_q[$];
  int blk_re[BLK];
  int blk_im[BLK];

  // Reference result handling for one component computed in plain integers.
  function automatic logic [DW-1:0] sc(input int v);
    int r;
    r = v;
`ifdef FFT_SDF_SCALE_EN
    r = (r + 1) >>> 1;
`endif
    return r[DW-1:0];
  endfunction

  function automatic int sx(input logic [DW-1:0] x);
    return int'($signed(x));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present one input cycle, then sample the registered outputs 1 ns after the edge.
  task automatic send(input bit en, input int re, input int im);
    ien   = en;
    iaddr = ia;
    idata = {re[DW-1:0], im[DW-1:0]};
    @(posedge iclk);
    #1;
    if (en) ia = ia + 1'b1;
    ien   = 1'b0;
    idata = '0;
  endtask

  task automatic dsamp(input int re);
    send(1'b1, re, 0);
  endtask

  task automatic didle();
    send(1'b0, 0, 0);
  endtask

  // Directed expectation for the cycle just sampled (imaginary part zero).
  task automatic eo(input string tag, input bit en, input logic [DW-1:0] re_e);
    logic [AW-1:0] prev;
    prev = exp_addr - 1'b1;
    chk({tag, ".oen"}, 32'(oen), 32'(en));
    if (en) begin
      chk({tag, ".data"}, odata, {re_e, {DW{1'b0}}});
      chk({tag, ".addr"}, 32'(oaddr), 32'(exp_addr));
      exp_addr = exp_addr + 1'b1;
    end else begin
      chk({tag, ".data"}, odata, 32'h0);
      chk({tag, ".addr"}, 32'(oaddr), 32'(prev));
    end
  endtask

  // Random section: every emitted sample must be the next one the model predicts.
  task automatic rcheck();
    logic [2*DW-1:0] e;
    if (oen) begin
      if (exp_q.size() == 0) begin
        chk("rnd.spurious_oen", 32'(oen), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("rnd.data", odata, e);
        chk("rnd.addr", 32'(oaddr), 32'(exp_addr));
        exp_addr = exp_addr + 1'b1;
      end
    end else begin
      chk("rnd.idle_data", odata, 32'h0);
    end
  endtask

  initial begin
    int re, im, r32, nb;

    // Reset state
    repeat (2) @(posedge iclk);
    #1;
    chk("rst.oen",   32'(oen),   32'h0);
    chk("rst.data",  odata,      32'h0);
    chk("rst.addr",  32'(oaddr), 32'h7);
    rst = 1'b0;

    // Single block then idle drain
    dsamp(1); eo("t1.s0", 0, 0);
    dsamp(2); eo("t1.s1", 0, 0);
    dsamp(3); eo("t1.s2", 1, sc(4));
    dsamp(4); eo("t1.s3", 1, sc(6));
    didle();  eo("t1.d0", 1, sc(-2));
    didle();  eo("t1.d1", 1, sc(-2));
    didle();  eo("t1.hold", 0, 0);

    // Back-to-back blocks
    dsamp(1); eo("t2.s0", 0, 0);
    dsamp(2); eo("t2.s1", 0, 0);
    dsamp(3); eo("t2.s2", 1, sc(4));
    dsamp(4); eo("t2.s3", 1, sc(6));
    dsamp(5); eo("t2.s4", 1, sc(-2));
    dsamp(6); eo("t2.s5", 1, sc(-2));
    dsamp(7); eo("t2.s6", 1, sc(12));
    dsamp(8); eo("t2.s7", 1, sc(14));
    didle();  eo("t2.d0", 1, sc(-2));
    didle();  eo("t2.d1", 1, sc(-2));
    didle();  eo("t2.hold", 0, 0);

    // Drain paused by an idle cycle after the next block started loading
    dsamp(1); eo("t3.s0", 0, 0);
    dsamp(2); eo("t3.s1", 0, 0);
    dsamp(3); eo("t3.s2", 1, sc(4));
    dsamp(4); eo("t3.s3", 1, sc(6));
    dsamp(5); eo("t3.y0", 1, sc(-2));
    didle();  eo("t3.pause", 0, 0);
    dsamp(6); eo("t3.y1", 1, sc(-2));
    dsamp(7); eo("t3.y2", 1, sc(12));
    dsamp(8); eo("t3.y3", 1, sc(14));
    didle();  eo("t3.d0", 1, sc(-2));
    didle();  eo("t3.d1", 1, sc(-2));
    didle();  eo("t3.hold", 0, 0);

    // Bubble inside the calc phase
    dsamp(1); eo("t4.s0", 0, 0);
    dsamp(2); eo("t4.s1", 0, 0);
    dsamp(3); eo("t4.s2", 1, sc(4));
    didle();  eo("t4.gap0", 0, 0);
    didle();  eo("t4.gap1", 0, 0);
    didle();  eo("t4.gap2", 0, 0);
    dsamp(4); eo("t4.s3", 1, sc(6));
    didle();  eo("t4.d0", 1, sc(-2));
    didle();  eo("t4.d1", 1, sc(-2));
    didle();  eo("t4.hold", 0, 0);

    // Full-scale operands: wrap or round depending on the build
    dsamp(32'h7FFF); eo("t5.s0", 0, 0);
    dsamp(0);        eo("t5.s1", 0, 0);
    dsamp(1);        eo("t5.s2", 1, sc(32'h7FFF + 1));
    dsamp(0);        eo("t5.s3", 1, sc(0));
    didle();         eo("t5.d0", 1, sc(32'h7FFF - 1));
    didle();         eo("t5.d1", 1, sc(0));
    didle();         eo("t5.hold", 0, 0);

    // Reset between the two drain outputs
    dsamp(1); eo("t6.s0", 0, 0);
    dsamp(2); eo("t6.s1", 0, 0);
    dsamp(3); eo("t6.s2", 1, sc(4));
    dsamp(4); eo("t6.s3", 1, sc(6));
    didle();  eo("t6.d0", 1, sc(-2));
    rst = 1'b1;
    #1;
    chk("t6.rst.oen",  32'(oen),   32'h0);
    chk("t6.rst.data", odata,      32'h0);
    chk("t6.rst.addr", 32'(oaddr), 32'h7);
    @(posedge iclk);
    #1;
    rst = 1'b0;
    exp_addr = '0;
    ia = '0;
    didle();  eo("t6.after0", 0, 0);
    didle();  eo("t6.after1", 0, 0);
    didle();  eo("t6.after2", 0, 0);

    // Randomized blocks with random bubbles in every phase
    for (int b = 0; b < 40; b++) begin
      for (int p = 0; p < BLK; p++) begin
        nb = 0;
        while ($urandom_range(3) == 0 && nb < 3) begin
          didle();
          rcheck();
          nb++;
        end
        r32 = $urandom;
        re = sx(r32[DW-1:0]);
        r32 = $urandom;
        im = sx(r32[DW-1:0]);
        blk_re[p] = re;
        blk_im[p] = im;
        if (p >= H) exp_q.push_back({sc(blk_re[p-H] + re), sc(blk_im[p-H] + im)});
        if (p == BLK - 1) begin
          for (int k = 0; k < H; k++)
            exp_q.push_back({sc(blk_re[k] - blk_re[k+H]), sc(blk_im[k] - blk_im[k+H])});
        end
        send(1'b1, re, im);
        rcheck();
      end
    end
    for (int i = 0; i < 2 * H + 4; i++) begin
      didle();
      rcheck();
    end
    chk("rnd.leftover", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
